// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard unit: RV32I opcodes, scoreboard states,
// and the forward-select width helper.
package hazard_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  // Select codes: 0 = regfile, 1..num_fwd = stages, num_fwd+1 = hard zero.
  function automatic int unsigned sel_width(input int unsigned num_fwd);
    return $clog2(num_fwd + 2);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. Perf counter outputs exist only
// when HAZARD_PERF_CNT_EN is defined.
interface hazard_unit_if
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_FWD = 2
);
  localparam int unsigned SEL_W = sel_width(NUM_FWD);

  logic [31:0]          id_instr_i;
  logic                 id_valid_i;
  logic [5*NUM_FWD-1:0] fwd_rd_addr_i;
  logic [NUM_FWD-1:0]   fwd_wr_en_i;
  logic [NUM_FWD-1:0]   fwd_rdy_i;
  logic                 branch_taken_i;
  logic                 mem_wait_i;
  logic                 mc_start_i;
  logic [4:0]           mc_rd_addr_i;
  logic                 mc_done_i;
  logic                 stall_o;
  logic                 flush_o;
  logic [SEL_W-1:0]     fwd_sel_rs1_o;
  logic [SEL_W-1:0]     fwd_sel_rs2_o;
  logic                 mc_busy_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]          perf_stall_cnt_o;
  logic [31:0]          perf_flush_cnt_o;
`endif

  modport master (
    output id_instr_i, id_valid_i, fwd_rd_addr_i, fwd_wr_en_i, fwd_rdy_i,
           branch_taken_i, mem_wait_i, mc_start_i, mc_rd_addr_i, mc_done_i,
    input  stall_o, flush_o, fwd_sel_rs1_o, fwd_sel_rs2_o, mc_busy_o
`ifdef HAZARD_PERF_CNT_EN
    , input perf_stall_cnt_o, perf_flush_cnt_o
`endif
  );

  modport slave (
    input  id_instr_i, id_valid_i, fwd_rd_addr_i, fwd_wr_en_i, fwd_rdy_i,
           branch_taken_i, mem_wait_i, mc_start_i, mc_rd_addr_i, mc_done_i,
    output stall_o, flush_o, fwd_sel_rs1_o, fwd_sel_rs2_o, mc_busy_o
`ifdef HAZARD_PERF_CNT_EN
    , output perf_stall_cnt_o, perf_flush_cnt_o
`endif
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding priority match: youngest writing stage wins, and a
// not-yet-computed match is reported as a load-use hazard.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned SEL_W   = sel_width(NUM_FWD)
) (
  input  logic [4:0]           rs_addr_i,
  input  logic                 rs_used_i,
  input  logic [5*NUM_FWD-1:0] fwd_rd_addr_i,
  input  logic [NUM_FWD-1:0]   fwd_wr_en_i,
  input  logic [NUM_FWD-1:0]   fwd_rdy_i,
  output logic [SEL_W-1:0]     sel_o,
  output logic                 not_rdy_o
);

  // NOTE: every output gets a default before any branch, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    sel_o     = '0;
    not_rdy_o = 1'b0;
    if (rs_used_i) begin
      if (rs_addr_i == 5'd0) begin
        sel_o = SEL_W'(NUM_FWD + 1);
      end else begin
        // Scan oldest to youngest so the youngest match is written last.
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
          if (fwd_wr_en_i[k] && (fwd_rd_addr_i[5*k +: 5] == rs_addr_i)) begin
            sel_o     = SEL_W'(k + 1);
            not_rdy_o = ~fwd_rdy_i[k];
          end
        end
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard unit: forwarding selects, load-use/scoreboard/structural
// stalls, branch flush. Optional perf counters via HAZARD_PERF_CNT_EN.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_FWD      = 2,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  hazard_unit_if.slave hz
);

  localparam int unsigned SEL_W      = sel_width(NUM_FWD);
  localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used;

  assign opcode = hz.id_instr_i[6:0];
  assign rs1    = hz.id_instr_i[19:15];
  assign rs2    = hz.id_instr_i[24:20];

  always_comb begin
    rs1_used = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    rs2_used = (opcode == OPC_RTYPE) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  end

  logic [SEL_W-1:0] sel_rs1, sel_rs2;
  logic             nrdy_rs1, nrdy_rs2;

  hazard_fwd_sel #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_rs1 (
    .rs_addr_i    (rs1),
    .rs_used_i    (rs1_used),
    .fwd_rd_addr_i(hz.fwd_rd_addr_i),
    .fwd_wr_en_i  (hz.fwd_wr_en_i),
    .fwd_rdy_i    (hz.fwd_rdy_i),
    .sel_o        (sel_rs1),
    .not_rdy_o    (nrdy_rs1)
  );

  hazard_fwd_sel #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_rs2 (
    .rs_addr_i    (rs2),
    .rs_used_i    (rs2_used),
    .fwd_rd_addr_i(hz.fwd_rd_addr_i),
    .fwd_wr_en_i  (hz.fwd_wr_en_i),
    .fwd_rdy_i    (hz.fwd_rdy_i),
    .sel_o        (sel_rs2),
    .not_rdy_o    (nrdy_rs2)
  );

  mc_state_e  state_q, state_d;
  logic [4:0] mc_rd_q, mc_rd_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mc_rd_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_rd_q     <= mc_rd_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // A second issue while BUSY is a structural stall, not a new tracked op.
  always_comb begin
    state_d = state_q;
    mc_rd_d = mc_rd_q;
    case (state_q)
      IDLE: if (hz.mc_start_i) begin
        state_d = BUSY;
        mc_rd_d = hz.mc_rd_addr_i;
      end
      BUSY:    if (hz.mc_done_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic branch_go, flush_raw, stall_raw;
  logic load_use, sb_raw, structural;

  assign branch_go = hz.id_valid_i && hz.branch_taken_i;
  assign flush_raw = (flush_cnt_q != 3'd0) || branch_go;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (branch_go)                flush_cnt_d = FLUSH_LOAD;
    else if (flush_cnt_q != 3'd0) flush_cnt_d = flush_cnt_q - 3'd1;
  end

  always_comb begin
    load_use   = nrdy_rs1 || nrdy_rs2;
    sb_raw     = (state_q == BUSY) && (mc_rd_q != 5'd0) &&
                 ((rs1_used && (rs1 == mc_rd_q)) || (rs2_used && (rs2 == mc_rd_q)));
    structural = (state_q == BUSY) && hz.mc_start_i;
    stall_raw  = (hz.id_valid_i && (load_use || sb_raw || structural)) || hz.mem_wait_i;
  end

  // Flush wins over stall unless memory is waiting, then both assert.
  assign hz.stall_o       = rst_ni && (flush_raw ? hz.mem_wait_i : stall_raw);
  assign hz.flush_o       = rst_ni && flush_raw;
  assign hz.fwd_sel_rs1_o = rst_ni ? sel_rs1 : '0;
  assign hz.fwd_sel_rs2_o = rst_ni ? sel_rs2 : '0;
  assign hz.mc_busy_o     = rst_ni && (state_q == BUSY);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (hz.stall_o) perf_stall_q <= perf_stall_q + 32'd1;
      if (hz.flush_o) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign hz.perf_stall_cnt_o = perf_stall_q;
  assign hz.perf_flush_cnt_o = perf_flush_q;
`endif

endmodule
